streaming_dwc_down: RTL

//   Downsizing AXI-Stream data width converter placed directly downstream of a StreamingFIFO.

---
 rtl/streaming_dwc_down_pkg.sv | 45 ++++
 rtl/streaming_dwc_down_if.sv | 18 +
 rtl/streaming_dwc_chunk_mux.sv | 28 ++
 rtl/streaming_dwc_down.sv | 119 +++++++++++
 4 files changed

// File: rtl/streaming_dwc_down_pkg.sv
// Package stream_dwc_pkg: shared types and width helpers for the downsizing
// stream converter.
//   state_t      - holding-register occupancy state (empty / full)
//   clog2        - ceiling log2, usable in constant expressions
//   ratio_of     - number of output chunks per input word
//   idx_width    - width of the chunk index (at least 1 bit)
//   cnt_width    - width of the optional occupancy count, clog2(RATIO)+1
//   widths_ok    - legality of an IN_WIDTH/OUT_WIDTH pair, checked at elaboration
package stream_dwc_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int ratio_of(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // A zero-width index is not legal, so RATIO==1 keeps a constant 1-bit index.
  function automatic int idx_width(input int in_w, input int out_w);
    return (ratio_of(in_w, out_w) > 1) ? clog2(ratio_of(in_w, out_w)) : 1;
  endfunction

  function automatic int cnt_width(input int in_w, input int out_w);
    return clog2(ratio_of(in_w, out_w)) + 1;
  endfunction

  function automatic bit widths_ok(input int in_w, input int out_w);
    return (out_w > 0) && (in_w >= out_w) && ((in_w % out_w) == 0);
  endfunction

endpackage

// File: rtl/streaming_dwc_down_if.sv
// AXI-Stream style channel used on both sides of the converter.
//   tdata  - payload, W bits
//   tvalid - driven by the master
//   tready - driven by the slave
// Handshake: a beat transfers on a rising clock edge where tvalid && tready.
// Once the master raises tvalid it holds tvalid and tdata stable until that
// transfer; tvalid never waits for tready, while tready may depend
// combinationally on the other side of the slave.
interface streaming_dwc_down_if #(
  parameter int W = 8
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/streaming_dwc_chunk_mux.sv
// streaming_dwc_chunk_mux: purely combinational selection of one OUT_WIDTH
// chunk out of an IN_WIDTH word; chunk 0 is the least-significant slice.
//   hold  in  IN_WIDTH  word being emitted
//   idx   in  IDX_W     chunk index, 0..RATIO-1
//   chunk out OUT_WIDTH selected slice
module streaming_dwc_chunk_mux
  import stream_dwc_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  localparam int RATIO    = ratio_of(IN_WIDTH, OUT_WIDTH),
  localparam int IDX_W    = idx_width(IN_WIDTH, OUT_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]  hold,
  input  logic [IDX_W-1:0]     idx,
  output logic [OUT_WIDTH-1:0] chunk
);

  always_comb begin
    chunk = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == IDX_W'(i)) begin
        chunk = hold[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/streaming_dwc_down.sv
// streaming_dwc_down: downsizing stream width converter. Takes one IN_WIDTH
// word and emits it as RATIO = IN_WIDTH/OUT_WIDTH beats, least-significant
// chunk first, one beat per cycle with no bubble between words.
//   ap_clk     in   clock, rising edge
//   ap_rst     in   asynchronous active-high reset
//   in0_V_V    slave  channel, IN_WIDTH data (from the StreamingFIFO)
//   out_V_V    master channel, OUT_WIDTH data (to the next stage)
//   count      out  chunks still held incl. the current one; present only
//                   when DWC_COUNT_EN is defined
//   dbg_state  out  holding-register state (empty/full)
// Optional feature macro: DWC_COUNT_EN.
module streaming_dwc_down
  import stream_dwc_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  streaming_dwc_down_if.slave          in0_V_V,
  streaming_dwc_down_if.master         out_V_V,
`ifdef DWC_COUNT_EN
  output logic [cnt_width(IN_WIDTH, OUT_WIDTH)-1:0] count,
`endif
  output state_t                       dbg_state
);

  localparam int RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W = idx_width(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W = cnt_width(IN_WIDTH, OUT_WIDTH);

  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_width
    $error("streaming_dwc_down: IN_WIDTH must be a positive multiple of OUT_WIDTH");
  end

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic                  full;
  logic                  last;
  logic                  in_fire;
  logic                  out_fire;

  assign full = (state_q == ST_FULL);
  assign last = full && (idx_q == IDX_W'(RATIO - 1));

  // Accept a new word while the last chunk leaves, so words chain with no
  // gap; this makes input ready combinational on output ready.
  assign in0_V_V.tready = !full || (last && out_V_V.tready);
  assign out_V_V.tvalid = full;

  assign in_fire  = in0_V_V.tvalid && in0_V_V.tready;
  assign out_fire = full && out_V_V.tready;

  streaming_dwc_chunk_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_chunk_mux (
    .hold  (hold_q),
    .idx   (idx_q),
    .chunk (out_V_V.tdata)
  );

  // A load takes priority over retiring the last chunk in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (in_fire) begin
      hold_d  = in0_V_V.tdata;
      idx_d   = '0;
      state_d = ST_FULL;
    end else if (out_fire) begin
      if (last) begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign dbg_state = state_q;

`ifdef DWC_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered from the next-state values so it moves in step with idx/full.
  always_comb begin
    cnt_d = '0;
    if (state_d == ST_FULL) begin
      cnt_d = CNT_W'(RATIO) - CNT_W'(idx_d);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
`endif

endmodule
